// File: rtl/usb4_lane_scrambler.sv
// Multi-lane, multi-bit-per-clock Galois LFSR scrambler/descrambler for the USB4 logical layer.
// Each lane advances its own LFSR DW steps per accepted, non-bypassed beat; output is a single register stage.
module usb4_lane_scrambler #(
  parameter int unsigned LANES = 2,
  parameter int unsigned DW = 8,
  parameter int unsigned LFSR_W = 23,
  parameter logic [LFSR_W-1:0] POLY = 23'h210125,
  parameter logic [LANES*LFSR_W-1:0] SEEDS = {23'h0607BB, 23'h1DBFBC}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   scr_rst,
  input  logic                   bypass,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*DW-1:0]    in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*DW-1:0]    out_data,
  output logic                   rst_ack,
  output logic [LFSR_W-1:0]      lfsr0_dbg
);

  localparam int unsigned BW = LANES * DW;

  logic [LFSR_W-1:0] lfsr     [LANES];
  logic [LFSR_W-1:0] lfsr_nxt [LANES];
  logic [LFSR_W-1:0] start;
  logic [LFSR_W-1:0] walk;
  logic              key;
  logic [BW-1:0]     scr_data;
  logic              accept;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign lfsr0_dbg = lfsr[0];

  // Bit-serial walk unrolled DW times per lane; a restart substitutes the seed as the start state.
  always_comb begin
    scr_data = '0;
    start    = '0;
    walk     = '0;
    key      = 1'b0;
    for (int n = 0; n < LANES; n++) begin
      lfsr_nxt[n] = '0;
    end
    for (int n = 0; n < LANES; n++) begin
      start = scr_rst ? SEEDS[n*LFSR_W +: LFSR_W] : lfsr[n];
      walk  = start;
      for (int i = 0; i < DW; i++) begin
        key = walk[LFSR_W-1];
        scr_data[n*DW + i] = in_data[n*DW + i] ^ key;
        walk = {walk[LFSR_W-2:0], 1'b0} ^ (key ? POLY : '0);
      end
      lfsr_nxt[n] = (accept && !bypass) ? walk : start;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < LANES; n++) begin
        lfsr[n] <= SEEDS[n*LFSR_W +: LFSR_W];
      end
    end else begin
      for (int n = 0; n < LANES; n++) begin
        lfsr[n] <= lfsr_nxt[n];
      end
    end
  end

  // Output register: overwritten on accept, otherwise drained by out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      rst_ack   <= 1'b0;
    end else begin
      rst_ack <= scr_rst;
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= bypass ? in_data : scr_data;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_usb4_lane_scrambler.sv
// Directed checks of usb4_lane_scrambler (LANES=2, DW=8) plus a scrambler->descrambler round trip.
module tb_usb4_lane_scrambler;

  localparam logic [22:0] SEED0   = 23'h1DBFBC;
  localparam logic [22:0] SEED1   = 23'h0607BB;
  localparam logic [22:0] POLY_TB = 23'h210125;

  logic        clk;
  logic        rst;
  logic        scr_rst, bypass, in_valid, in_ready, out_valid, out_ready, rst_ack;
  logic [15:0] in_data, out_data;
  logic [22:0] lfsr0_dbg;

  logic        ra_scr_rst, ra_bypass, ra_in_valid, ra_in_ready, ra_out_valid, ra_rst_ack;
  logic [15:0] ra_in_data, ra_out_data;
  logic [22:0] ra_dbg;
  logic        rb_scr_rst, rb_bypass, rb_in_ready, rb_out_valid, rb_out_ready, rb_rst_ack;
  logic [15:0] rb_out_data;
  logic [22:0] rb_dbg;

  int checks;
  int errors;
  logic [22:0] m_lfsr [2];

  usb4_lane_scrambler u_dut (
    .clk(clk), .rst(rst), .scr_rst(scr_rst), .bypass(bypass),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rst_ack(rst_ack), .lfsr0_dbg(lfsr0_dbg)
  );

  usb4_lane_scrambler u_rt_a (
    .clk(clk), .rst(rst), .scr_rst(ra_scr_rst), .bypass(ra_bypass),
    .in_valid(ra_in_valid), .in_ready(ra_in_ready), .in_data(ra_in_data),
    .out_valid(ra_out_valid), .out_ready(rb_in_ready), .out_data(ra_out_data),
    .rst_ack(ra_rst_ack), .lfsr0_dbg(ra_dbg)
  );

  usb4_lane_scrambler u_rt_b (
    .clk(clk), .rst(rst), .scr_rst(rb_scr_rst), .bypass(rb_bypass),
    .in_valid(ra_out_valid), .in_ready(rb_in_ready), .in_data(ra_out_data),
    .out_valid(rb_out_valid), .out_ready(rb_out_ready), .out_data(rb_out_data),
    .rst_ack(rb_rst_ack), .lfsr0_dbg(rb_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The descrambler sees each beat one cycle later, so its controls are delayed to match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_scr_rst <= 1'b0;
      rb_bypass  <= 1'b0;
    end else begin
      rb_scr_rst <= ra_scr_rst;
      rb_bypass  <= ra_bypass;
    end
  end

  task automatic model_restart();
    m_lfsr[0] = SEED0;
    m_lfsr[1] = SEED1;
  endtask

  task automatic model_beat(input logic [15:0] d, input logic byp, input logic srst,
                            output logic [15:0] o);
    logic [22:0] s;
    logic k;
    o = '0;
    for (int n = 0; n < 2; n++) begin
      s = srst ? ((n == 0) ? SEED0 : SEED1) : m_lfsr[n];
      for (int i = 0; i < 8; i++) begin
        k = s[22];
        o[n*8 + i] = byp ? d[n*8 + i] : (d[n*8 + i] ^ k);
        if (!byp) s = {s[21:0], 1'b0} ^ (k ? POLY_TB : 23'h0);
      end
      m_lfsr[n] = s;
    end
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    checks++; if (rst_ack !== 1'b0) begin errors++; $display("FAIL reset_rst_ack got %0b want 0", rst_ack); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (lfsr0_dbg !== 23'h1DBFBC) begin errors++; $display("FAIL reset_lfsr0 got %h want 1dbfbc", lfsr0_dbg); end
    model_restart();
  endtask

  task automatic test_seed();
    logic [15:0] exp;
    scr_rst = 1'b1; in_valid = 1'b1; in_data = 16'h0000; bypass = 1'b0;
    model_beat(16'h0000, 1'b0, 1'b1, exp);
    @(negedge clk);
    scr_rst = 1'b0; in_valid = 1'b0;
    checks++; if (out_data[7:0] !== 8'h6C) begin errors++; $display("FAIL seed_lane0 got %h want 6c", out_data[7:0]); end
    checks++; if (out_data !== exp) begin errors++; $display("FAIL seed_both_lanes got %h want %h", out_data, exp); end
    checks++; if (rst_ack !== 1'b1) begin errors++; $display("FAIL seed_rst_ack got %0b want 1", rst_ack); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL seed_out_valid got %0b want 1", out_valid); end
    checks++; if (lfsr0_dbg !== 23'h498C2E) begin errors++; $display("FAIL seed_lfsr_after got %h want 498c2e", lfsr0_dbg); end
    @(negedge clk);
    checks++; if (rst_ack !== 1'b0) begin errors++; $display("FAIL seed_rst_ack_pulse got %0b want 0", rst_ack); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL seed_out_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_bypass();
    logic [15:0] vec [6];
    logic [5:0]  byp_pat;
    logic [15:0] exp;
    logic [22:0] prev;
    vec = '{16'h1234, 16'hBCBC, 16'hA55A, 16'hBCBC, 16'hBCBC, 16'h0F0F};
    byp_pat = 6'b011010;
    scr_rst = 1'b1;
    model_restart();
    @(negedge clk);
    scr_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      prev = m_lfsr[0];
      in_valid = 1'b1; in_data = vec[i]; bypass = byp_pat[i];
      model_beat(vec[i], byp_pat[i], 1'b0, exp);
      @(negedge clk);
      checks++; if (out_data !== exp) begin errors++; $display("FAIL bypass_data[%0d] got %h want %h", i, out_data, exp); end
      checks++; if (lfsr0_dbg !== m_lfsr[0]) begin errors++; $display("FAIL bypass_lfsr[%0d] got %h want %h", i, lfsr0_dbg, m_lfsr[0]); end
      if (byp_pat[i]) begin
        checks++; if (out_data !== 16'hBCBC) begin errors++; $display("FAIL bypass_raw[%0d] got %h want bcbc", i, out_data); end
        checks++; if (lfsr0_dbg !== prev) begin errors++; $display("FAIL bypass_hold[%0d] got %h want %h", i, lfsr0_dbg, prev); end
      end
    end
    in_valid = 1'b0; bypass = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [15:0] exp0, exp1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h1111;
    model_beat(16'h1111, 1'b0, 1'b0, exp0);
    @(negedge clk);
    in_data = 16'h2222;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid got %0b want 1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0b want 0", in_ready); end
    checks++; if (out_data !== exp0) begin errors++; $display("FAIL bp_first_data got %h want %h", out_data, exp0); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (out_data !== exp0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got data %h ready %0b want %h ready 0", c, out_data, in_ready, exp0);
      end
    end
    out_ready = 1'b1;
    model_beat(16'h2222, 1'b0, 1'b0, exp1);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== exp1) begin
      errors++; $display("FAIL bp_release got valid %0b data %h want 1 %h", out_valid, out_data, exp1);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %0b want 0", out_valid); end
    checks++; if (lfsr0_dbg !== m_lfsr[0]) begin errors++; $display("FAIL bp_lfsr got %h want %h", lfsr0_dbg, m_lfsr[0]); end
  endtask

  task automatic test_restart_bp();
    logic [15:0] exp0, exp1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h3C3C;
    model_beat(16'h3C3C, 1'b0, 1'b0, exp0);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rbp_in_ready got %0b want 0", in_ready); end
    in_data = 16'h4D4D; scr_rst = 1'b1;
    model_restart();
    @(negedge clk);
    scr_rst = 1'b0;
    checks++; if (out_data !== exp0) begin errors++; $display("FAIL rbp_held got %h want %h", out_data, exp0); end
    checks++; if (rst_ack !== 1'b1) begin errors++; $display("FAIL rbp_rst_ack got %0b want 1", rst_ack); end
    checks++; if (lfsr0_dbg !== SEED0) begin errors++; $display("FAIL rbp_reload got %h want %h", lfsr0_dbg, SEED0); end
    out_ready = 1'b1;
    model_beat(16'h4D4D, 1'b0, 1'b0, exp1);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_data !== exp1) begin errors++; $display("FAIL rbp_from_seed got %h want %h", out_data, exp1); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [15:0] exp;
    in_valid = 1'b1; in_data = 16'h5A5A;
    model_beat(16'h5A5A, 1'b0, 1'b0, exp);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== exp) begin
      errors++; $display("FAIL ar_pre got valid %0b data %h want 1 %h", out_valid, out_data, exp);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid got %0b want 0", out_valid); end
    checks++; if (lfsr0_dbg !== 23'h1DBFBC) begin errors++; $display("FAIL ar_lfsr0 got %h want 1dbfbc", lfsr0_dbg); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL ar_out_data got %h want 0000", out_data); end
    model_restart();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_roundtrip();
    logic [15:0] q [$];
    logic [15:0] exp;
    int sent;
    int recv;
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 4000 && !(sent >= 1000 && q.size() == 0); cyc++) begin
      if (rb_out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rt_extra got %h want none", rb_out_data);
        end else begin
          exp = q.pop_front();
          recv++;
          if (rb_out_data !== exp) begin errors++; $display("FAIL rt_data[%0d] got %h want %h", recv, rb_out_data, exp); end
        end
      end
      if (sent < 1000) begin
        ra_in_valid = ($urandom_range(0, 9) != 0);
        ra_in_data  = 16'($urandom);
        ra_bypass   = ($urandom_range(0, 7) == 0);
        ra_scr_rst  = ($urandom_range(0, 49) == 0);
      end else begin
        ra_in_valid = 1'b0; ra_bypass = 1'b0; ra_scr_rst = 1'b0;
      end
      if (ra_in_valid && ra_in_ready) begin
        q.push_back(ra_in_data);
        sent++;
      end
      @(negedge clk);
    end
    checks++; if (recv !== 1000) begin errors++; $display("FAIL rt_count got %0d want 1000", recv); end
    checks++; if (ra_dbg !== rb_dbg) begin errors++; $display("FAIL rt_lfsr_sync got %h want %h", rb_dbg, ra_dbg); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; scr_rst = 1'b0; bypass = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    ra_scr_rst = 1'b0; ra_bypass = 1'b0; ra_in_valid = 1'b0; ra_in_data = '0; rb_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_seed();
    test_bypass();
    test_backpressure();
    test_restart_bp();
    test_async_reset();
    test_roundtrip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
